// File: rtl/ram_buf_pkg.sv
// Shared definitions for the RAM prefetch buffer: FSM state encoding and a
// constant-foldable ceil(log2) helper.
package ram_buf_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StFetch = 2'b01,
    StDrain = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pfb_fifo.sv
// Synchronous DEPTH x DATA_W FIFO; pointers carry an extra wrap bit so that
// full and empty are distinguished without a separate counter.
module pfb_fifo
  import ram_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 128,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
);

  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: reads are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ram_prefetch_buf.sv
// Prefetches a run of RAM rows (ascending or descending) into a credit-limited
// FIFO and streams them out with first/last-row byte enables.
module ram_prefetch_buf
  import ram_buf_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned LW    = clog2(DEPTH) + 1,
  localparam int unsigned BW    = clog2(DATA_W / 8),
  localparam int unsigned NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ADDR_W-1:0] cmd_start_addr,
  input  logic [LW-1:0]     cmd_len,
  input  logic              cmd_dir,
  input  logic [BW-1:0]     cmd_start_byte,
  input  logic [BW-1:0]     cmd_end_byte,
  output logic              ram_rd_vld,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic              ram_rsp_vld,
  input  logic [DATA_W-1:0] ram_rsp_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [NB-1:0]     out_byte_en,
  output logic              out_last,
  input  logic              flush,
  output logic              busy
);

  state_e state_q, state_d;

  logic [ADDR_W-1:0] start_addr_q;
  logic [LW-1:0]     len_q;
  logic              dir_q;
  logic [BW-1:0]     start_byte_q, end_byte_q;
  logic [LW-1:0]     issued_q, returned_q, popped_q, discard_q;

  logic              active, cmd_fire, flush_act, credit_ok, rd_fire, push, pop;
  logic              fifo_empty, fifo_full, first_row, last_row;
  logic [LW-1:0]     inflight, fifo_count;
  logic [ADDR_W-1:0] rd_offset;
  logic [BW-1:0]     hi_shift;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] fifo_head;

  assign active    = (state_q != StIdle);
  assign cmd_rdy   = (state_q == StIdle) && (discard_q == '0);
  assign cmd_fire  = cmd_vld && cmd_rdy;
  assign flush_act = flush && active;
  assign inflight  = issued_q - returned_q;

  // Buffered plus outstanding rows may never exceed the FIFO, so responses cannot overflow.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (LW + 1)'(DEPTH);
  assign rd_fire   = (state_q == StFetch) && (issued_q < len_q) && credit_ok && !flush;
  assign rd_offset = ADDR_W'(issued_q);

  assign ram_rd_vld  = rd_fire;
  assign ram_rd_addr = !rd_fire ? '0 :
                       dir_q    ? start_addr_q - rd_offset : start_addr_q + rd_offset;

  assign push = ram_rsp_vld && (discard_q == '0) && active && !flush;
  assign pop  = out_vld && out_rdy && !flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (cmd_fire) state_d = StFetch;
      StFetch: if (issued_q == len_q) state_d = StDrain;
      StDrain: if (pop && out_last && (inflight == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_act) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_addr_q <= '0;
      len_q        <= '0;
      dir_q        <= 1'b0;
      start_byte_q <= '0;
      end_byte_q   <= '0;
      issued_q     <= '0;
      returned_q   <= '0;
      popped_q     <= '0;
    end else if (cmd_fire) begin
      start_addr_q <= cmd_start_addr;
      len_q        <= cmd_len;
      dir_q        <= cmd_dir;
      start_byte_q <= cmd_start_byte;
      end_byte_q   <= cmd_end_byte;
      issued_q     <= '0;
      returned_q   <= '0;
      popped_q     <= '0;
    end else begin
      if (rd_fire) issued_q   <= issued_q + 1'b1;
      if (push)    returned_q <= returned_q + 1'b1;
      if (pop)     popped_q   <= popped_q + 1'b1;
    end
  end

  // A response landing in the flush cycle is already counted in inflight, so remove it here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_q <= '0;
    end else if (flush_act) begin
      discard_q <= inflight - LW'(ram_rsp_vld);
    end else if (ram_rsp_vld && (discard_q != '0)) begin
      discard_q <= discard_q - 1'b1;
    end
  end

  pfb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush_act),
    .push      (push),
    .push_data (ram_rsp_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign first_row = (popped_q == '0);
  assign last_row  = (popped_q == (len_q - LW'(1)));
  assign hi_shift  = BW'(NB - 1) - end_byte_q;

  always_comb begin
    be = '1;
    if (first_row) be = be & ({NB{1'b1}} << start_byte_q);
    if (last_row)  be = be & ({NB{1'b1}} >> hi_shift);
  end

  assign out_vld     = !fifo_empty;
  assign out_data    = out_vld ? fifo_head : '0;
  assign out_byte_en = out_vld ? be : '0;
  assign out_last    = out_vld && last_row;
  assign busy        = active;

  a_cmd_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
    cmd_fire |-> ((cmd_len != '0) && (cmd_len <= LW'(DEPTH))));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && fifo_full) |-> pop);

endmodule

// File: tb/tb_ram_prefetch_buf.sv
// Randomised bench for ram_prefetch_buf: a RAM responder with fixed per-command
// latency plus a queue-based reference model checked every cycle.
module tb_ram_prefetch_buf;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 16;
  localparam int LW     = 5;
  localparam int BW     = 4;
  localparam int NB     = 16;

  logic              clk, rst_n;
  logic              cmd_vld, cmd_rdy, cmd_dir;
  logic [ADDR_W-1:0] cmd_start_addr;
  logic [LW-1:0]     cmd_len;
  logic [BW-1:0]     cmd_start_byte, cmd_end_byte;
  logic              ram_rd_vld, ram_rsp_vld;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rsp_data, out_data;
  logic              out_vld, out_rdy, out_last, flush, busy;
  logic [NB-1:0]     out_byte_en;

  ram_prefetch_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_vld        (cmd_vld),
    .cmd_rdy        (cmd_rdy),
    .cmd_start_addr (cmd_start_addr),
    .cmd_len        (cmd_len),
    .cmd_dir        (cmd_dir),
    .cmd_start_byte (cmd_start_byte),
    .cmd_end_byte   (cmd_end_byte),
    .ram_rd_vld     (ram_rd_vld),
    .ram_rd_addr    (ram_rd_addr),
    .ram_rsp_vld    (ram_rsp_vld),
    .ram_rsp_data   (ram_rsp_data),
    .out_vld        (out_vld),
    .out_rdy        (out_rdy),
    .out_data       (out_data),
    .out_byte_en    (out_byte_en),
    .out_last       (out_last),
    .flush          (flush),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tag: 0 live, 1 to be discarded after flush, 2 dropped after reset
  typedef struct {
    logic [7:0] addr;
    int         due;
    int         tag;
  } rsp_t;

  rsp_t       rq[$];
  int         cyc, lat, rdy_mode;
  bit         active;
  int         m_len, m_issued, m_popped, m_fifo, m_sb, m_eb;
  logic [7:0] m_start;
  bit         m_dir;
  logic [7:0] log_addr[$];
  logic [15:0] log_be[$];
  bit         log_last[$];
  int         checks, failures;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] ram_word(input logic [7:0] a);
    return {4{a, ~a, a ^ 8'h5a, 8'(a * 8'd3)}};
  endfunction

  function automatic logic [7:0] row_addr(input int i);
    return m_dir ? m_start - 8'(i) : m_start + 8'(i);
  endfunction

  // Byte b of row i is valid unless it precedes start_byte in the first row
  // or follows end_byte in the last row.
  function automatic logic [15:0] exp_be(input int i, input int len, input int sb, input int eb);
    logic [15:0] be;
    for (int b = 0; b < 16; b++) be[b] = (i > 0 || b >= sb) && (i < len - 1 || b <= eb);
    return be;
  endfunction

  // Per-cycle compare, model update and RAM responder, all at the falling edge.
  initial begin
    rsp_t r;
    bit   drv, exp_rdy, exp_rd, pop, is_last;
    int   stale_n;
    cyc = 0;
    ram_rsp_vld = 1'b0;
    ram_rsp_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      exp_rdy = 1'b0;
      exp_rd  = 1'b0;
      pop     = 1'b0;
      is_last = 1'b0;
      if (!rst_n) begin
        active = 1'b0; m_fifo = 0; m_issued = 0; m_popped = 0;
        foreach (rq[k]) rq[k].tag = 2;
        chk("rst_cmd_rdy", cmd_rdy, 1);
        chk("rst_rd_vld", ram_rd_vld, 0);
        chk("rst_rd_addr", ram_rd_addr, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_byte_en", out_byte_en, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
      end else begin
        stale_n = 0;
        foreach (rq[k]) if (rq[k].tag == 1) stale_n++;
        exp_rdy = !active && stale_n == 0;
        exp_rd  = active && m_issued < m_len && (m_issued - m_popped) < DEPTH && !flush;
        chk("cmd_rdy", cmd_rdy, exp_rdy);
        chk("busy", busy, active);
        chk("rd_vld", ram_rd_vld, exp_rd);
        chk("out_vld", out_vld, m_fifo > 0);
        if (exp_rd && ram_rd_vld) begin
          chk("rd_addr", ram_rd_addr, row_addr(m_issued));
          log_addr.push_back(ram_rd_addr);
        end
        if (m_fifo > 0 && out_vld) begin
          chk("out_data", out_data, ram_word(row_addr(m_popped)));
          chk("byte_en", out_byte_en, exp_be(m_popped, m_len, m_sb, m_eb));
          chk("out_last", out_last, m_popped == m_len - 1);
          if (out_rdy && !flush) begin
            log_be.push_back(out_byte_en);
            log_last.push_back(out_last);
          end
        end
        pop     = (m_fifo > 0) && out_rdy && !flush;
        is_last = pop && (m_popped == m_len - 1);
      end

      // RAM: drive whatever is due, then record this cycle's request
      drv = 1'b0;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        drv = 1'b1;
        ram_rsp_vld = 1'b1;
        ram_rsp_data = ram_word(r.addr);
      end else begin
        ram_rsp_vld = 1'b0;
        ram_rsp_data = '0;
      end
      if (ram_rd_vld) rq.push_back('{addr: ram_rd_addr, due: cyc + lat, tag: 0});

      if (rst_n) begin
        if (exp_rd) m_issued++;
        if (pop) begin m_popped++; m_fifo--; end
        if (drv && r.tag == 0 && active && !flush) m_fifo++;
        if (is_last) active = 1'b0;
        if (flush && active) begin
          foreach (rq[k]) if (rq[k].tag == 0) rq[k].tag = 1;
          active = 1'b0;
          m_fifo = 0;
        end
        if (cmd_vld && exp_rdy) begin
          active = 1'b1;
          m_start = cmd_start_addr; m_len = int'(cmd_len); m_dir = cmd_dir;
          m_sb = int'(cmd_start_byte); m_eb = int'(cmd_end_byte);
          m_issued = 0; m_popped = 0; m_fifo = 0;
        end
      end
    end
  end

  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((active || rq.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("idle_timeout", n >= 3000, 0);
  endtask

  task automatic send(input logic [7:0] a, input int len, input bit dir, input int sb,
                      input int eb, input int l);
    wait_idle();
    lat = l;
    log_addr.delete(); log_be.delete(); log_last.delete();
    @(posedge clk); #1;
    cmd_start_addr = a; cmd_len = LW'(len); cmd_dir = dir;
    cmd_start_byte = BW'(sb); cmd_end_byte = BW'(eb); cmd_vld = 1'b1;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0;
    rst_n = 1'b0; cmd_vld = 1'b0; flush = 1'b0; rdy_mode = 0; lat = 1;
    cmd_start_addr = '0; cmd_len = '0; cmd_dir = 1'b0; cmd_start_byte = '0; cmd_end_byte = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ascending, partial first/last rows
    send(8'h10, 4, 0, 2, 13, 1);
    wait_idle();
    chk("t033_nreads", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t033_addr", log_addr[i], 8'h10 + 8'(i));
    end
    chk("t033_nrows", log_be.size(), 4);
    if (log_be.size() == 4) begin
      chk("t033_be0", log_be[0], 16'hFFFC);
      chk("t033_be1", log_be[1], 16'hFFFF);
      chk("t033_be2", log_be[2], 16'hFFFF);
      chk("t033_be3", log_be[3], 16'h3FFF);
      chk("t033_last0", log_last[0], 0);
      chk("t033_last3", log_last[3], 1);
    end

    // Descending across address zero
    send(8'h01, 3, 1, 0, 15, 1);
    wait_idle();
    chk("t034_nreads", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("t034_a0", log_addr[0], 8'h01);
      chk("t034_a1", log_addr[1], 8'h00);
      chk("t034_a2", log_addr[2], 8'hFF);
    end

    // Full-depth command with output stalled
    rdy_mode = 2;
    send(8'h40, 16, 0, 0, 15, 1);
    repeat (30) @(posedge clk);
    chk("t035_reads_stalled", log_addr.size(), 16);
    chk("t035_rows_stalled", log_be.size(), 0);
    rdy_mode = 0;
    wait_idle();
    chk("t035_rows", log_be.size(), 16);

    // Single row, both masks
    send(8'h22, 1, 0, 5, 9, 1);
    wait_idle();
    chk("t036_nrows", log_be.size(), 1);
    if (log_be.size() == 1) begin
      chk("t036_be", log_be[0], 16'h03E0);
      chk("t036_last", log_last[0], 1);
    end

    // Flush with responses in flight
    send(8'h80, 8, 0, 0, 15, 4);
    n = 0;
    while (log_addr.size() < 3 && n < 100) begin @(posedge clk); n++; end
    chk("t037_issue_timeout", n >= 100, 0);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("t037_busy", busy, 0);
    chk("t037_cmd_rdy_held", cmd_rdy, 0);
    chk("t037_out_vld", out_vld, 0);
    wait_idle();
    chk("t037_nreads", log_addr.size(), 3);
    chk("t037_nrows", log_be.size(), 0);
    send(8'hC0, 5, 1, 3, 12, 2);
    wait_idle();
    chk("t037_next_rows", log_be.size(), 5);

    // Reset while draining with five rows buffered
    rdy_mode = 2;
    send(8'h30, 5, 0, 0, 15, 1);
    n = 0;
    while (!(m_fifo == 5 && m_issued == 5) && n < 100) begin @(posedge clk); n++; end
    chk("t038_fill_timeout", n >= 100, 0);
    chk("t038_vld_before", out_vld, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t038_out_vld", out_vld, 0);
    chk("t038_busy", busy, 0);
    chk("t038_cmd_rdy", cmd_rdy, 1);
    chk("t038_byte_en", out_byte_en, 0);
    chk("t038_out_data", out_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    rdy_mode = 0;

    // Random commands, latencies, backpressure and occasional flush
    for (int t = 0; t < 40; t++) begin
      rdy_mode = int'($urandom_range(0, 1));
      send(8'($urandom), int'($urandom_range(1, DEPTH)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           int'($urandom_range(1, 6)));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
      end
      wait_idle();
    end

    rdy_mode = 0;
    wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_prefetch_buf.md
RAM_PREFETCH_BUF -- requirements
Module: ram_prefetch_buf

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128: RAM row and output data width in bits (multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 8: RAM row address width.
REQ-003 The block SHALL have parameter DEPTH, default 16: buffer entries (power of two, >=2); LW = clog2(DEPTH)+1; BW = clog2(DATA_W/8).
REQ-004 Port clk, input, 1: single clock; all logic rising-edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port cmd_vld / cmd_rdy, input / output, 1 / 1: command handshake; cmd_rdy=1 only in IDLE.
REQ-007 Port cmd_start_addr, input, ADDR_W: first row to read.
REQ-008 Port cmd_len, input, LW: rows to read, legal 1..DEPTH.
REQ-009 Port cmd_dir, input, 1: 0 = ascending, 1 = descending addresses.
REQ-010 Port cmd_start_byte / cmd_end_byte, input, BW each: first valid byte of first row / last valid byte of last row.
REQ-011 Port ram_rd_vld / ram_rd_addr, output, 1 / ADDR_W: RAM read request (no backpressure).
REQ-012 Port ram_rsp_vld / ram_rsp_data, input, 1 / DATA_W: RAM read response, in order, any latency >=1.
REQ-013 Port out_vld / out_rdy, output / input, 1 / 1: output handshake to MXU.
REQ-014 Port out_data / out_byte_en / out_last, output, DATA_W / DATA_W/8 / 1: row data, byte enables, final row flag.
REQ-015 Port flush, input, 1: synchronous abort of current command.
REQ-016 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-017 States SHALL be IDLE, FETCH, DRAIN; IDLE->FETCH on cmd_vld&cmd_rdy; FETCH->DRAIN when issued count == len; DRAIN->IDLE when last row is accepted (out_vld&out_rdy&out_last) and inflight==0.
REQ-018 On command accept the block SHALL capture all cmd_* fields and clear issued, returned and popped counters.
REQ-019 Request i (0-based) SHALL use address start_addr+i (dir=0) or start_addr-i (dir=1), modulo 2^ADDR_W.
REQ-020 ram_rd_vld SHALL assert in FETCH when issued<len and (occupancy+inflight)<DEPTH; first request SHALL issue the cycle after command accept.
REQ-021 Each ram_rsp_vld SHALL write one FIFO entry; responses SHALL never overflow (guaranteed by REQ-020 credit rule).
REQ-022 out_vld SHALL equal FIFO non-empty; out_data SHALL be the FIFO head, held stable while out_vld&~out_rdy.
REQ-023 out_byte_en SHALL be all-ones except: first row clears bytes below start_byte; last row clears bytes above end_byte; single-row command applies both.
REQ-024 out_last SHALL be 1 on the row with popped index len-1.
REQ-025 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; full-and-pop-and-push SHALL be legal.
REQ-026 Zero-bubble throughput: with out_rdy=1 and 1-cycle RAM latency, one row per cycle after a 2-cycle startup.
REQ-027 flush SHALL empty the FIFO, return to IDLE next cycle, and discard exactly the inflight responses still pending (tracked by discard counter); cmd_rdy SHALL stay 0 until discard counter is 0.
REQ-028 cmd_vld outside IDLE SHALL be ignored; cmd_len=0 or >DEPTH is illegal (assertion only).

Reset
REQ-029 On rst_n low: state IDLE, all counters and pointers 0, FIFO empty; outputs cmd_rdy=1, ram_rd_vld=0, ram_rd_addr=0, out_vld=0, out_last=0, out_byte_en=0, out_data=0, busy=0.
REQ-030 Reset asserted mid-command SHALL abandon all state; responses arriving after reset release SHALL be ignored only if state is IDLE with discard=0 (i.e. dropped).

Structure
REQ-031 Shared package ram_buf_pkg SHALL hold the FSM state encodings (IDLE=2'b00, FETCH=2'b01, DRAIN=2'b10) and the clog2 helper.
REQ-032 One sub-module pfb_fifo (DEPTH x DATA_W, sync, wrap-around pointers with extra MSB for full/empty) SHALL hold data.

Verification
REQ-033 Addr 0x10, len 4, dir 0, bytes 2/13, out_rdy=1 -> reads 0x10..0x13, out_last on 4th, byte_en 0xFFFC,0xFFFF,0xFFFF,0x3FFF.
REQ-034 Addr 0x01, len 3, dir 1 -> reads 0x01,0x00,0xFF (wrap).
REQ-035 Len 16, out_rdy=0 for 30 cycles -> exactly 16 reads issued, no 17th, then 16 rows drain in order.
REQ-036 Len 1, start 5, end 9 -> single row, out_last=1, byte_en 0x03E0.
REQ-037 Len 8, RAM latency 4, flush after 3 issues -> IDLE next cycle, 3 late responses dropped, cmd_rdy returns after last one, next command clean.
REQ-038 rst_n low during DRAIN with 5 rows buffered -> all outputs at reset values same cycle.
